fifo_access_scheduler: RTL and testbench

- Sequences all accesses to the shared 16-deep x 8-bit synchronous FIFO.
- Round-robin arbitration between NREQ write producers and one read consumer; issues at most one FIFO operation per cycle (wr or rd, never both).
- Guarantees the read side is not starved by the FIFO's write-over-read priority.
- Generates the FIFO's active-high synchronous reset from the system async reset and a soft flush.

---
 rtl/fifo_access_scheduler.sv | 141 ++++++++++++++
 tb/tb_fifo_access_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_access_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_access_scheduler
//  Description : Round-robin access sequencer for a shared 16x8 synchronous
//                FIFO: NREQ write producers, one read consumer, one op/cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_access_scheduler #(
    parameter int NREQ         = 4,
    parameter int DW           = 8,
    parameter int MAX_WR_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [NREQ-1:0]    wr_req,
    input  logic [NREQ*DW-1:0] wr_data,
    output logic [NREQ-1:0]    wr_gnt,
    input  logic               rd_req,
    output logic               rd_gnt,
    output logic               rd_valid,
    output logic [DW-1:0]      rd_data,
    output logic               fifo_rst,
    output logic               fifo_wr,
    output logic               fifo_rd,
    output logic [DW-1:0]      fifo_din,
    input  logic [DW-1:0]      fifo_dout,
    input  logic               fifo_full,
    input  logic               fifo_empty
);

    localparam int              c_IW         = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int              c_CW         = c_IW + 1;
    localparam logic [c_CW-1:0] c_NREQ       = c_CW'(NREQ);
    localparam logic [c_IW-1:0] c_LAST_INIT  = c_IW'(NREQ - 1);
    localparam logic [3:0]      c_STREAK_MAX = 4'd15;
    localparam logic [3:0]      c_BURST      = 4'(MAX_WR_BURST);

    logic [1:0]      r_sync;
    logic            r_flush;
    logic [c_IW-1:0] r_last_wr;
    logic [3:0]      r_wr_streak;
    logic            r_rd_valid;

    logic            w_blocked;
    logic            w_can_wr;
    logic            w_can_rd;
    logic            w_do_wr;
    logic            w_do_rd;
    logic            w_win_found;
    logic [c_IW-1:0] w_win_idx;
    logic [c_CW-1:0] w_cand;

    // Reset synchronizer: asserts asynchronously, releases after two edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_flush <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], 1'b0};
            r_flush <= flush;
        end
    end

    assign fifo_rst  = r_sync[1] | r_flush;
    assign w_blocked = fifo_rst | ~rst_n;

    // Round-robin search from the requester after the last winner.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = r_last_wr;
        w_cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = {1'b0, r_last_wr} + c_CW'(k);
            if (w_cand >= c_NREQ) begin
                w_cand = w_cand - c_NREQ;
            end
            if (!w_win_found && wr_req[w_cand[c_IW-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand[c_IW-1:0];
            end
        end
    end

    assign w_can_wr = w_win_found & ~fifo_full & ~w_blocked;
    assign w_can_rd = rd_req & ~fifo_empty & ~w_blocked;

    // A read displaces a write only once the write streak has hit its budget.
    assign w_do_rd = w_can_rd & (~w_can_wr | (r_wr_streak >= c_BURST));
    assign w_do_wr = w_can_wr & ~w_do_rd;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
            assign wr_gnt[gi] = w_do_wr & (w_win_idx == c_IW'(gi));
        end
    endgenerate

    always_comb begin
        fifo_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (wr_gnt[i]) begin
                fifo_din = wr_data[i*DW +: DW];
            end
        end
    end

    assign fifo_wr = w_do_wr;
    assign fifo_rd = w_do_rd;
    assign rd_gnt  = w_do_rd;
    assign rd_data = fifo_dout;
    assign rd_valid = r_rd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_wr <= c_LAST_INIT;
        end else if (w_do_wr) begin
            r_last_wr <= w_win_idx;
        end
    end

    // Streak counts writes that bypassed a serviceable read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_streak <= '0;
        end else if (flush || w_do_rd || !rd_req || fifo_empty) begin
            r_wr_streak <= '0;
        end else if (w_do_wr && (r_wr_streak != c_STREAK_MAX)) begin
            r_wr_streak <= r_wr_streak + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_do_rd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_access_scheduler.sv
`default_nettype none
// Testbench for fifo_access_scheduler: behavioural FIFO, queue-based reference
// model of the scheduling rules, and a read-data scoreboard monitor.
module tb_fifo_access_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MAXB = 4;
    localparam int DEPTH = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               flush = 1'b0;
    logic [NREQ-1:0]    wr_req = '0;
    logic [NREQ*DW-1:0] wr_data = '0;
    logic               rd_req = 1'b0;
    logic [NREQ-1:0]    wr_gnt;
    logic               rd_gnt;
    logic               rd_valid;
    logic [DW-1:0]      rd_data;
    logic               fifo_rst;
    logic               fifo_wr;
    logic               fifo_rd;
    logic [DW-1:0]      fifo_din;
    logic [DW-1:0]      fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;

    fifo_access_scheduler #(.NREQ(NREQ), .DW(DW), .MAX_WR_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .fifo_rst(fifo_rst), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
        .fifo_din(fifo_din), .fifo_dout(fifo_dout),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared 16x8 synchronous FIFO the scheduler drives.
    logic [DW-1:0] fmem [DEPTH];
    int fcnt = 0;
    int fwp = 0;
    int frp = 0;
    always @(posedge clk) begin
        if (fifo_rst) begin
            fcnt <= 0; fwp <= 0; frp <= 0;
        end else if (fifo_wr && fcnt < DEPTH) begin
            fmem[fwp] <= fifo_din;
            fwp  <= (fwp + 1) % DEPTH;
            fcnt <= fcnt + 1;
        end else if (fifo_rd && fcnt > 0) begin
            fifo_dout <= fmem[frp];
            frp  <= (frp + 1) % DEPTH;
            fcnt <= fcnt - 1;
        end
    end
    assign fifo_full  = (fcnt == DEPTH);
    assign fifo_empty = (fcnt == 0);

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model state
    typedef struct {
        int            stamp;
        logic [DW-1:0] data;
    } rd_exp_t;

    int            m_last = NREQ - 1;
    int            m_streak = 0;
    int            m_hold = 2;
    logic          m_flush_prev = 1'b0;
    logic [DW-1:0] m_q [$];
    rd_exp_t       sb_q [$];

    int            dmode = 0;
    logic [DW-1:0] dsel [NREQ];

    task automatic model_step();
        logic            m_rst, full, empty, can_wr, can_rd, do_wr, do_rd;
        int              win, c;
        logic [NREQ-1:0] exp_gnt;
        logic [DW-1:0]   exp_din;
        rd_exp_t         e;
        if (!rst_n) begin
            m_hold = 2; m_streak = 0; m_last = NREQ - 1; m_flush_prev = 1'b0;
            sb_q.delete();
        end
        m_rst = !rst_n || (m_hold > 0) || m_flush_prev;
        full  = (m_q.size() == DEPTH);
        empty = (m_q.size() == 0);
        win = -1;
        for (int k = 1; k <= NREQ; k++) begin
            c = (m_last + k) % NREQ;
            if (win < 0 && wr_req[c]) win = c;
        end
        can_wr = (win >= 0) && !full && !m_rst;
        can_rd = rd_req && !empty && !m_rst;
        do_rd  = can_rd && (!can_wr || m_streak >= MAXB);
        do_wr  = can_wr && !do_rd;
        exp_gnt = '0;
        exp_din = '0;
        if (do_wr) begin
            exp_gnt[win] = 1'b1;
            exp_din = wr_data[win*DW +: DW];
        end
        check("fifo_rst", fifo_rst, m_rst);
        check("wr_gnt", wr_gnt, exp_gnt);
        check("rd_gnt", rd_gnt, do_rd);
        check("fifo_wr", fifo_wr, do_wr);
        check("fifo_rd", fifo_rd, do_rd);
        check("fifo_empty", fifo_empty, empty);
        check("fifo_full", fifo_full, full);
        if (do_wr) check("fifo_din", fifo_din, exp_din);
        // effects of the coming clock edge
        if (rst_n) begin
            if (flush || do_rd || !rd_req || empty) m_streak = 0;
            else if (do_wr && m_streak < 15) m_streak++;
            if (do_wr) m_last = win;
        end
        if (m_rst) m_q.delete();
        else if (do_wr) m_q.push_back(exp_din);
        else if (do_rd) begin
            e.stamp = cyc;
            e.data  = m_q.pop_front();
            sb_q.push_back(e);
        end
        if (rst_n) begin
            if (m_hold > 0) m_hold--;
            m_flush_prev = flush;
        end
    endtask

    task automatic cycle(input logic [NREQ-1:0] req, input logic rd, input logic fl, input logic rn);
        @(posedge clk);
        #1;
        rst_n  = rn;
        wr_req = req;
        rd_req = rd;
        flush  = fl;
        for (int i = 0; i < NREQ; i++)
            wr_data[i*DW +: DW] = (dmode != 0) ? dsel[i] : DW'($urandom);
        #1;
        model_step();
    endtask

    // Read-data monitor: each rd_valid must match the oldest expected read.
    initial begin
        rd_exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (rd_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rd_valid_unexpected: actual=1 required=0 (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("rd_latency", e.stamp, cyc - 1);
                    check("rd_data", rd_data, e.data);
                end
            end else if (sb_q.size() > 0 && sb_q[0].stamp < cyc) begin
                tests++; fails++;
                $display("FAIL rd_valid_missing: actual=0 required=1 (t=%0t)", $time);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        dmode = 0;
        repeat (3) cycle(4'b1111, 1'b1, 1'b0, 1'b0);
        // release and round-robin fill to full with A0+i
        for (int i = 0; i < NREQ; i++) dsel[i] = 8'hA0 + 8'(i);
        dmode = 1;
        repeat (22) cycle(4'b1111, 1'b0, 1'b0, 1'b1);
        dmode = 0;
        repeat (20) cycle(4'b0000, 1'b1, 1'b0, 1'b1);
        // empty read then a single 5C write
        repeat (3) cycle(4'b0000, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < NREQ; i++) dsel[i] = 8'h5C;
        dmode = 1;
        cycle(4'b0001, 1'b1, 1'b0, 1'b1);
        dmode = 0;
        repeat (3) cycle(4'b0000, 1'b1, 1'b0, 1'b1);
        // starvation guard from two stored entries
        repeat (2) cycle(4'b0011, 1'b0, 1'b0, 1'b1);
        repeat (30) cycle(4'b0011, 1'b1, 1'b0, 1'b1);
        repeat (20) cycle(4'b0000, 1'b1, 1'b0, 1'b1);
        // flush with ten stored entries
        repeat (10) cycle(NREQ'($urandom_range(1, 15)), 1'b0, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1, 1'b1);
        cycle(4'b1111, 1'b0, 1'b0, 1'b1);
        repeat (4) cycle(4'b1111, 1'b1, 1'b0, 1'b1);
        // randomized traffic with occasional flush
        repeat (1500)
            cycle(NREQ'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0), 1'b1);
        // async reset one cycle after a read grant
        repeat (5) cycle(4'b1111, 1'b0, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #4 rst_n = 1'b0;
        #1;
        check("async_rd_valid", rd_valid, 1'b0);
        check("async_fifo_rst", fifo_rst, 1'b1);
        check("async_wr_gnt", wr_gnt, '0);
        check("async_rd_gnt", rd_gnt, 1'b0);
        m_hold = 2; m_streak = 0; m_last = NREQ - 1; m_flush_prev = 1'b0;
        m_q.delete();
        sb_q.delete();
        repeat (2) cycle(4'b1111, 1'b1, 1'b0, 1'b0);
        repeat (6) cycle(4'b1111, 1'b1, 1'b0, 1'b1);
        repeat (4) cycle(4'b0000, 1'b0, 1'b0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
